// File: rtl/window_seq_pkg.sv
// Shared types and constants for the window sequencing controller.
package window_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OPEN,
        DONE,
        CFGERR
    } state_t;

    localparam int CNT_W_DEF = 4;

    // Window lengths that exercise all interesting timing relations in a bench.
    localparam int WIN_LEN_HINT_MIN = 3;
    localparam int WIN_LEN_HINT_MAX = 5;

endpackage

// File: rtl/window_seq_ctrl_rise_det.sv
// Registered rising-edge detector with asynchronous active-high reset.
module rise_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= 1'b0;
        else     q <= d;
    end

    assign rise = d & ~q;

endmodule

// File: rtl/window_seq_ctrl.sv
// Turns a trigger rising edge into open-window / inner handshake / close sequence
// and reports whether the inner acknowledge landed inside the window.
module window_seq_ctrl
    import window_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic [CNT_W-1:0] cfg_inner_dly,
    input  logic [CNT_W-1:0] cfg_win_len,
    input  logic             inner_ack,
    output logic             win_open,
    output logic             win_close,
    output logic             inner_req,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err,
    output logic             trig_drop
);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, dly_l, len_l;
    logic             ok, req_hold, drop_q, rise, req_active;

    rise_det u_trig_rise (
        .clk  (clk),
        .rst  (rst),
        .d    (trig),
        .rise (rise)
    );

    always_comb begin
        state_nx   = state;
        win_open   = 1'b0;
        win_close  = 1'b0;
        req_active = 1'b0;
        done       = 1'b0;
        pass       = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    if (cfg_win_len == '0 || cfg_inner_dly >= cfg_win_len) state_nx = CFGERR;
                    else                                                   state_nx = OPEN;
                end
            end
            OPEN: begin
                win_open   = 1'b1;
                // Request is combinational on its first cycle so an ack there counts.
                req_active = req_hold | (cnt == dly_l);
                if (cnt == len_l) begin
                    win_close = 1'b1;
                    state_nx  = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                pass     = ok;
                err      = ~ok;
                state_nx = IDLE;
            end
            CFGERR: begin
                err      = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign inner_req = req_active;
    assign busy      = (state != IDLE);
    assign trig_drop = drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            dly_l    <= '0;
            len_l    <= '0;
            ok       <= 1'b0;
            req_hold <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state  <= state_nx;
            drop_q <= rise & (state != IDLE);
            case (state)
                IDLE: begin
                    if (rise) begin
                        dly_l    <= cfg_inner_dly;
                        len_l    <= cfg_win_len;
                        cnt      <= '0;
                        ok       <= 1'b0;
                        req_hold <= 1'b0;
                    end
                end
                OPEN: begin
                    if (cnt != len_l) cnt <= cnt + 1'b1;
                    if (req_active) begin
                        if (inner_ack) begin
                            ok       <= 1'b1;
                            req_hold <= 1'b0;
                        end else begin
                            req_hold <= 1'b1;
                        end
                    end
                end
                default: req_hold <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_window_seq_ctrl.sv
// Scenario bench for window_seq_ctrl against a timeline model built from run start times.
module tb_window_seq_ctrl;

    localparam int N_MAX = 80;
    localparam int B_OPEN = 7, B_CLOSE = 6, B_REQ = 5, B_BUSY = 4;
    localparam int B_DONE = 3, B_PASS = 2, B_ERR = 1, B_DROP = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trig = 1'b0;
    logic [3:0] cfg_inner_dly = '0;
    logic [3:0] cfg_win_len = '0;
    logic       inner_ack = 1'b0;
    logic       win_open, win_close, inner_req, busy, done, pass, err, trig_drop;
    logic [7:0] outs;

    int checks = 0;
    int passes = 0;

    logic       trig_v [N_MAX];
    logic       ack_v  [N_MAX];
    logic [3:0] dly_v  [N_MAX];
    logic [3:0] len_v  [N_MAX];
    logic [7:0] exp_v  [N_MAX + 20];

    window_seq_ctrl #(.CNT_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .trig          (trig),
        .cfg_inner_dly (cfg_inner_dly),
        .cfg_win_len   (cfg_win_len),
        .inner_ack     (inner_ack),
        .win_open      (win_open),
        .win_close     (win_close),
        .inner_req     (inner_req),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err           (err),
        .trig_drop     (trig_drop)
    );

    always #5 clk = ~clk;

    assign outs = {win_open, win_close, inner_req, busy, done, pass, err, trig_drop};

    task automatic clear_stim(input int dly, input int len);
        for (int i = 0; i < N_MAX; i++) begin
            trig_v[i] = 1'b0;
            ack_v[i]  = 1'b0;
            dly_v[i]  = 4'(dly);
            len_v[i]  = 4'(len);
        end
    endtask

    // Expected outputs per cycle, derived from each accepted run's start cycle.
    task automatic build_model(input int n);
        int endc, s, dly, len, closec, ackc;
        bit rise;
        endc = -1;
        for (int i = 0; i < N_MAX + 20; i++) exp_v[i] = '0;
        for (int c = 0; c < n; c++) begin
            rise = trig_v[c] && !(c > 0 && trig_v[c-1]);
            if (!rise) continue;
            if (c <= endc) begin
                exp_v[c+1][B_DROP] = 1'b1;
                continue;
            end
            s   = c;
            dly = int'(dly_v[c]);
            len = int'(len_v[c]);
            if (len == 0 || dly >= len) begin
                exp_v[s+1][B_BUSY] = 1'b1;
                exp_v[s+1][B_ERR]  = 1'b1;
                endc = s + 1;
            end else begin
                closec = s + 1 + len;
                ackc   = -1;
                for (int a = s + 1 + dly; a <= closec; a++)
                    if (ackc < 0 && ack_v[a]) ackc = a;
                for (int k = s + 1; k <= closec; k++) begin
                    exp_v[k][B_OPEN] = 1'b1;
                    exp_v[k][B_BUSY] = 1'b1;
                    if (k >= s + 1 + dly && k <= ((ackc >= 0) ? ackc : closec))
                        exp_v[k][B_REQ] = 1'b1;
                end
                exp_v[closec][B_CLOSE]  = 1'b1;
                exp_v[closec+1][B_BUSY] = 1'b1;
                exp_v[closec+1][B_DONE] = 1'b1;
                exp_v[closec+1][B_PASS] = (ackc >= 0);
                exp_v[closec+1][B_ERR]  = (ackc < 0);
                endc = closec + 1;
            end
        end
    endtask

    // Entered and left #1 after a posedge; samples outputs at the negedge of cycle c.
    task automatic step(input int c, output logic [7:0] got);
        trig          = trig_v[c];
        inner_ack     = ack_v[c];
        cfg_inner_dly = dly_v[c];
        cfg_win_len   = len_v[c];
        @(negedge clk);
        got = outs;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (outs !== 8'h00) $display("FAIL reset outs got=%b exp=%b", outs, 8'h00);
        else passes++;
        rst = 1'b0;
    endtask

    task automatic test_nominal();
        logic [7:0] got;
        clear_stim(1, 4);
        trig_v[0] = 1'b1; trig_v[1] = 1'b1; ack_v[3] = 1'b1;
        build_model(16);
        for (int c = 0; c < 16; c++) begin
            step(c, got);
            checks++;
            if (got !== exp_v[c]) $display("FAIL nominal cyc=%0d got=%b exp=%b", c, got, exp_v[c]);
            else passes++;
        end
    endtask

    task automatic test_late_ack();
        logic [7:0] got;
        clear_stim(1, 3);
        trig_v[0] = 1'b1;
        build_model(12);
        for (int c = 0; c < 12; c++) begin
            step(c, got);
            checks++;
            if (got !== exp_v[c]) $display("FAIL late_ack cyc=%0d got=%b exp=%b", c, got, exp_v[c]);
            else passes++;
        end
    endtask

    task automatic test_cfg_error(input int dly, input int len);
        logic [7:0] got;
        clear_stim(dly, len);
        trig_v[0] = 1'b1; trig_v[1] = 1'b1; ack_v[2] = 1'b1;
        build_model(8);
        for (int c = 0; c < 8; c++) begin
            step(c, got);
            checks++;
            if (got !== exp_v[c]) $display("FAIL cfg_error dly=%0d len=%0d cyc=%0d got=%b exp=%b", dly, len, c, got, exp_v[c]);
            else passes++;
        end
    endtask

    task automatic test_boundary_ack(input int ack_cyc);
        logic [7:0] got;
        clear_stim(4, 5);
        trig_v[0] = 1'b1; ack_v[ack_cyc] = 1'b1;
        build_model(12);
        for (int c = 0; c < 12; c++) begin
            step(c, got);
            checks++;
            if (got !== exp_v[c]) $display("FAIL boundary_ack ack=%0d cyc=%0d got=%b exp=%b", ack_cyc, c, got, exp_v[c]);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got;
        clear_stim(1, 4);
        trig_v[0] = 1'b1; trig_v[3] = 1'b1; trig_v[6] = 1'b1; trig_v[8] = 1'b1;
        ack_v[2] = 1'b1; ack_v[11] = 1'b1;
        build_model(20);
        for (int c = 0; c < 20; c++) begin
            step(c, got);
            checks++;
            if (got !== exp_v[c]) $display("FAIL back_to_back cyc=%0d got=%b exp=%b", c, got, exp_v[c]);
            else passes++;
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] got;
        clear_stim(1, 5);
        trig_v[0] = 1'b1; trig_v[1] = 1'b1; trig_v[2] = 1'b1;
        build_model(12);
        for (int c = 0; c < 3; c++) begin
            step(c, got);
            checks++;
            if (got !== exp_v[c]) $display("FAIL reset_mid pre cyc=%0d got=%b exp=%b", c, got, exp_v[c]);
            else passes++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (outs !== 8'h00) $display("FAIL reset_mid immediate got=%b exp=%b", outs, 8'h00);
        else passes++;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (outs !== 8'h00) $display("FAIL reset_mid held k=%0d got=%b exp=%b", k, outs, 8'h00);
            else passes++;
        end
        @(posedge clk);
        #1;
        trig = 1'b0;
        rst  = 1'b0;
        clear_stim(2, 5);
        trig_v[1] = 1'b1; ack_v[5] = 1'b1;
        build_model(14);
        for (int c = 0; c < 14; c++) begin
            step(c, got);
            checks++;
            if (got !== exp_v[c]) $display("FAIL reset_mid restart cyc=%0d got=%b exp=%b", c, got, exp_v[c]);
            else passes++;
        end
    endtask

    task automatic test_random(input int iter);
        logic [7:0] got;
        clear_stim(0, 0);
        for (int i = 0; i < 60; i++) begin
            dly_v[i] = 4'($urandom_range(0, 7));
            len_v[i] = 4'($urandom_range(0, 7));
            ack_v[i] = ($urandom_range(0, 2) == 0);
            trig_v[i] = (i < 48) ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        build_model(60);
        for (int c = 0; c < 60; c++) begin
            step(c, got);
            checks++;
            if (got !== exp_v[c]) $display("FAIL random it=%0d cyc=%0d got=%b exp=%b", iter, c, got, exp_v[c]);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_late_ack();
        test_cfg_error(5, 3);
        test_cfg_error(0, 0);
        test_cfg_error(3, 3);
        test_boundary_ack(6);
        test_boundary_ack(7);
        test_back_to_back();
        test_reset_mid_run();
        for (int it = 0; it < 6; it++) test_random(it);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
